wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 108 ++++++++++
 tb/tb_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-port arbiter: merges two producers into one register-file write port
// through an in-order pending-write queue with hazard lookup on queued entries.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    input  logic [AW-1:0]            a_waddr,
    input  logic [DW-1:0]            a_wdata,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [AW-1:0]            b_waddr,
    input  logic [DW-1:0]            b_wdata,
    output logic                     b_ready,
    output logic                     we,
    output logic [AW-1:0]            waddr,
    output logic [DW-1:0]            wdata,
    input  logic [AW-1:0]            raddr1,
    input  logic [AW-1:0]            raddr2,
    output logic                     pend1,
    output logic                     pend2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [PW-1:0] b_slot;
    logic [PW-1:0] offset;
    logic          a_en;
    logic          b_en;
    logic          pop;
    logic [CW-1:0] a_inc;
    logic [CW-1:0] b_inc;

    // Readiness looks only at occupancy before the edge; the concurrent pop is not credited.
    always_comb begin
        a_ready = rst && (count < FULL);
        a_en    = a_valid && a_ready && (a_waddr != '0);
        a_inc   = CW'(a_en);
        b_ready = rst && ((count + a_inc) < FULL);
        b_en    = b_valid && b_ready && (b_waddr != '0);
        b_inc   = CW'(b_en);
        pop     = (count != '0);
        b_slot  = wptr + PW'(a_en);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            if (pop) begin
                we    <= 1'b1;
                waddr <= addr_q[rptr];
                wdata <= data_q[rptr];
                rptr  <= rptr + PW'(1);
            end else begin
                we    <= 1'b0;
                waddr <= '0;
                wdata <= '0;
            end
            wptr  <= wptr + PW'(a_en) + PW'(b_en);
            count <= count + a_inc + b_inc - CW'(pop);
        end
    end

    // A is always stored ahead of B when both are taken in the same cycle.
    always_ff @(posedge clk) begin
        if (a_en) begin
            addr_q[wptr] <= a_waddr;
            data_q[wptr] <= a_wdata;
        end
        if (b_en) begin
            addr_q[b_slot] <= b_waddr;
            data_q[b_slot] <= b_wdata;
        end
    end

    // Only entries still in the queue count; the output stage is forwarded by the register file.
    always_comb begin
        pend1  = 1'b0;
        pend2  = 1'b0;
        offset = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - rptr;
            if ({1'b0, offset} < count) begin
                if (addr_q[i] == raddr1) pend1 = 1'b1;
                if (addr_q[i] == raddr2) pend2 = 1'b1;
            end
        end
        pend1 = pend1 && rst && (raddr1 != '0);
        pend2 = pend2 && rst && (raddr2 != '0);
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: hand-computed per-cycle vector table, then a queue-based
// reference model and write scoreboard for sustained, backpressured and random traffic.
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk;
    logic          rst;
    logic          a_valid;
    logic [AW-1:0] a_waddr;
    logic [DW-1:0] a_wdata;
    logic          a_ready;
    logic          b_valid;
    logic [AW-1:0] b_waddr;
    logic [DW-1:0] b_wdata;
    logic          b_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic          pend1;
    logic          pend2;
    logic [2:0]    count;

    wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_waddr(a_waddr), .a_wdata(a_wdata), .a_ready(a_ready),
        .b_valid(b_valid), .b_waddr(b_waddr), .b_wdata(b_wdata), .b_ready(b_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .pend1(pend1), .pend2(pend2),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          bv;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic          ear;
        logic          ebr;
        logic [2:0]    ecnt;
        logic          ewe;
        logic [AW-1:0] ewa;
        logic [DW-1:0] ewd;
        logic          ep1;
        logic          ep2;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int unsigned n_vec = 0;
    int unsigned n_mis = 0;
    vec_t        vecs[$];
    wr_t         mq[$];
    wr_t         sb[$];
    logic        mwe;

    function automatic vec_t v(
        input logic rs,
        input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
        input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
        input logic [AW-1:0] r1, input logic [AW-1:0] r2,
        input logic ear, input logic ebr, input logic [2:0] ecnt,
        input logic ewe, input logic [AW-1:0] ewa, input logic [DW-1:0] ewd,
        input logic ep1, input logic ep2);
        vec_t t;
        t.rst = rs; t.av = av; t.aa = aa; t.ad = ad; t.bv = bv; t.ba = ba; t.bd = bd;
        t.r1 = r1; t.r2 = r2; t.ear = ear; t.ebr = ebr; t.ecnt = ecnt;
        t.ewe = ewe; t.ewa = ewa; t.ewd = ewd; t.ep1 = ep1; t.ep2 = ep2;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // mode 0: held A/B streams until accepted, mode 1: random traffic, mode 2: idle drain
    task automatic run_stream(input int mode, input int unsigned cycles);
        int unsigned ai = 0;
        int unsigned bi = 0;
        int unsigned peak = 0;
        logic saw_bp = 1'b0;
        logic ea, eb, aen, ben, ep1, ep2;
        wr_t  w;
        for (int unsigned c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (mode == 1) begin
                a_valid = 1'($urandom_range(0, 1));
                a_waddr = AW'($urandom_range(0, 31));
                a_wdata = $urandom;
                b_valid = 1'($urandom_range(0, 1));
                b_waddr = AW'($urandom_range(0, 31));
                b_wdata = $urandom;
                raddr1  = AW'($urandom_range(0, 31));
                raddr2  = AW'($urandom_range(0, 31));
            end else if (mode == 0) begin
                a_valid = (ai < 8);
                a_waddr = AW'(1 + ai);
                a_wdata = 32'hA000 + ai;
                b_valid = (bi < 8);
                b_waddr = AW'(16 + bi);
                b_wdata = 32'hB000 + bi;
                raddr1  = AW'(1 + ai);
                raddr2  = AW'(16 + bi);
            end else begin
                a_valid = 1'b0; a_waddr = '0; a_wdata = '0;
                b_valid = 1'b0; b_waddr = '0; b_wdata = '0;
                raddr1  = '0;   raddr2  = '0;
            end
            #1;
            ea  = (mq.size() < DEPTH);
            aen = a_valid && ea && (a_waddr != 0);
            eb  = ((mq.size() + (aen ? 1 : 0)) < DEPTH);
            ben = b_valid && eb && (b_waddr != 0);
            ep1 = 1'b0;
            ep2 = 1'b0;
            foreach (mq[j]) begin
                if (raddr1 != 0 && mq[j].addr == raddr1) ep1 = 1'b1;
                if (raddr2 != 0 && mq[j].addr == raddr2) ep2 = 1'b1;
            end
            check("s.a_ready", a_ready, ea);
            check("s.b_ready", b_ready, eb);
            check("s.count", count, mq.size());
            check("s.pend1", pend1, ep1);
            check("s.pend2", pend2, ep2);
            check("s.we", we, mwe);
            if (we === 1'b1) begin
                if (sb.size() == 0) begin
                    check("s.spurious_we", we, 0);
                end else begin
                    w = sb.pop_front();
                    check("s.waddr", waddr, w.addr);
                    check("s.wdata", wdata, w.data);
                end
            end
            if (count > peak) peak = count;
            if (b_valid && !b_ready) saw_bp = 1'b1;
            @(posedge clk);
            mwe = (mq.size() != 0);
            if (mwe) void'(mq.pop_front());
            if (aen) begin w.addr = a_waddr; w.data = a_wdata; mq.push_back(w); sb.push_back(w); end
            if (ben) begin w.addr = b_waddr; w.data = b_wdata; mq.push_back(w); sb.push_back(w); end
            if (mode == 0) begin
                if (a_valid && ea) ai++;
                if (b_valid && eb) bi++;
            end
        end
        if (mode == 0) begin
            check("s.a_all_accepted", ai, 8);
            check("s.b_all_accepted", bi, 8);
            // continuous draining caps occupancy one below DEPTH
            check("s.peak_count", peak, DEPTH - 1);
            check("s.backpressure_seen", saw_bp, 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t;
        rst = 1'b0; a_valid = 1'b0; a_waddr = '0; a_wdata = '0;
        b_valid = 1'b0; b_waddr = '0; b_wdata = '0; raddr1 = '0; raddr2 = '0;
        mwe = 1'b0;

        //          rs av aa  ad      bv ba  bd      r1  r2  ar br cnt we wa  wd      p1 p2
        vecs.push_back(v(0, 1, 9, 'h99,  1, 10, 'h9A,  9, 10, 0, 0, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(1, 1, 3, 'h11,  0, 0,  0,     3, 0,  1, 1, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     3, 0,  1, 1, 1, 0, 0,  0,     1, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     3, 0,  1, 1, 0, 1, 3,  'h11,  0, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     0, 0,  1, 1, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(1, 1, 4, 'hA,   1, 5,  'hB,   0, 0,  1, 1, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     4, 5,  1, 1, 2, 0, 0,  0,     1, 1));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     4, 5,  1, 1, 1, 1, 4,  'hA,   0, 1));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     0, 0,  1, 1, 0, 1, 5,  'hB,   0, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     0, 0,  1, 1, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(1, 1, 8, 'h81,  1, 9,  'h91,  0, 0,  1, 1, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(1, 1, 10,'hA1,  1, 11, 'hB1,  8, 11, 1, 1, 2, 0, 0,  0,     1, 0));
        vecs.push_back(v(1, 1, 0, 'hFF,  1, 6,  'h1,   0, 0,  1, 1, 3, 1, 8,  'h81,  0, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     6, 0,  1, 1, 3, 1, 9,  'h91,  1, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     6, 0,  1, 1, 2, 1, 10, 'hA1,  1, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     6, 0,  1, 1, 1, 1, 11, 'hB1,  1, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     6, 0,  1, 1, 0, 1, 6,  'h1,   0, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     0, 0,  1, 1, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(1, 1, 7, 'h77,  0, 0,  0,     7, 0,  1, 1, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     7, 0,  1, 1, 1, 0, 0,  0,     1, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     7, 0,  1, 1, 0, 1, 7,  'h77,  0, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     0, 0,  1, 1, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(1, 1, 12,'hC,   1, 13, 'hD,   0, 0,  1, 1, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(1, 1, 14,'hE,   1, 15, 'hF,   13,15, 1, 1, 2, 0, 0,  0,     1, 0));
        vecs.push_back(v(0, 1, 16,'h10,  1, 17, 'h17,  13,14, 0, 0, 3, 1, 12, 'hC,   0, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     13,14, 1, 1, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     0, 0,  1, 1, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(1, 0, 0, 0,     0, 0,  0,     0, 0,  1, 1, 0, 0, 0,  0,     0, 0));

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            @(negedge clk);
            rst = t.rst;
            a_valid = t.av; a_waddr = t.aa; a_wdata = t.ad;
            b_valid = t.bv; b_waddr = t.ba; b_wdata = t.bd;
            raddr1 = t.r1; raddr2 = t.r2;
            #1;
            check($sformatf("v%0d.a_ready", i), a_ready, t.ear);
            check($sformatf("v%0d.b_ready", i), b_ready, t.ebr);
            check($sformatf("v%0d.count", i), count, t.ecnt);
            check($sformatf("v%0d.we", i), we, t.ewe);
            check($sformatf("v%0d.waddr", i), waddr, t.ewa);
            check($sformatf("v%0d.wdata", i), wdata, t.ewd);
            check($sformatf("v%0d.pend1", i), pend1, t.ep1);
            check($sformatf("v%0d.pend2", i), pend2, t.ep2);
            @(posedge clk);
        end

        run_stream(0, 30);
        run_stream(1, 300);
        run_stream(2, 8);
        check("end.scoreboard_empty", sb.size(), 0);
        check("end.count", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
